// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with flush, optional skid buffer and stall counter
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID_FULL} state_t;
  state_t              r_state;
  logic                r_in_ready;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_data;
  logic [CTRL_W-1:0]   r_sk_ctrl;
  logic [DATA_W-1:0]   r_sk_data;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_acc;
  logic                w_drn;
  assign out_valid = r_state != EMPTY;
  assign in_ready  = SKID ? r_in_ready : (!out_valid | out_ready);
  assign w_acc     = in_valid & in_ready;
  assign w_drn     = out_valid & out_ready;
  assign out_ctrl  = r_ctrl;
  assign out_data  = r_data;
  assign stall_cnt = r_cnt;
  // entry FSM: main/skid storage; r_ctrl is zeroed whenever main empties so bubbles carry no control
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_ctrl     <= '0;
      r_data     <= '0;
      r_sk_ctrl  <= '0;
      r_sk_data  <= '0;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_ctrl     <= '0;
    end else begin
      case (r_state)
        EMPTY:
          if (w_acc) begin
            r_state <= FULL;
            r_ctrl  <= in_ctrl;
            r_data  <= in_data;
          end
        FULL:
          if (w_acc && w_drn) begin
            r_ctrl <= in_ctrl;
            r_data <= in_data;
          end else if (w_acc) begin
            r_state    <= SKID_FULL;
            r_in_ready <= 1'b0;
            r_sk_ctrl  <= in_ctrl;
            r_sk_data  <= in_data;
          end else if (w_drn) begin
            r_state <= EMPTY;
            r_ctrl  <= '0;
          end
        SKID_FULL:
          if (w_drn) begin
            r_state    <= FULL;
            r_in_ready <= 1'b1;
            r_ctrl     <= r_sk_ctrl;
            r_data     <= r_sk_data;
          end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
          r_ctrl     <= '0;
        end
      endcase
    end
  // saturating count of stalled output cycles; clear wins, flush leaves it alone
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (stall_clr) r_cnt <= '0;
    else if (out_valid && !out_ready && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model random and directed checks of pipe_stage_reg (skid and non-skid)
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 111;
  logic clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0, stall_clr = 0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic rdy0, val0, rdy1, val1;
  logic [CW-1:0] oc0, oc1;
  logic [DW-1:0] od0, od1;
  logic [15:0] sc0;
  logic [3:0] sc1;
  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(val0), .out_ready(out_ready),
    .out_ctrl(oc0), .out_data(od0), .stall_clr(stall_clr), .stall_cnt(sc0));
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(val1), .out_ready(out_ready),
    .out_ctrl(oc1), .out_data(od1), .stall_clr(stall_clr), .stall_cnt(sc1));

  typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} pkt_t;
  pkt_t q0[$], q1[$];
  int s0 = 0, s1 = 0, vec = 0, err = 0;
  bit en = 0;

  function automatic bit mr0(); return q0.size() < 2; endfunction
  function automatic bit mr1(); return q1.size() == 0 || out_ready; endfunction

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // behavioural model: a bounded FIFO per instance plus a saturating stall counter
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0.delete(); q1.delete(); s0 = 0; s1 = 0;
    end else begin
      bit a0, a1;
      a0 = in_valid && mr0();
      a1 = in_valid && mr1();
      if (stall_clr) s0 = 0; else if (q0.size() > 0 && !out_ready && s0 < 65535) s0++;
      if (stall_clr) s1 = 0; else if (q1.size() > 0 && !out_ready && s1 < 15) s1++;
      if (flush) q0.delete();
      else begin
        if (q0.size() > 0 && out_ready) void'(q0.pop_front());
        if (a0) q0.push_back(pkt_t'({in_ctrl, in_data}));
      end
      if (flush) q1.delete();
      else begin
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (a1) q1.push_back(pkt_t'({in_ctrl, in_data}));
      end
    end
  end

  // compare DUT against model mid-cycle
  always @(negedge clk) if (en) begin
    chk("valid0", val0, q0.size() > 0);
    chk("ready0", rdy0, mr0());
    chk("stall0", sc0, s0);
    if (q0.size() > 0) begin
      chk("ctrl0", oc0, q0[0].c);
      chk("data0", od0, q0[0].d);
    end else chk("bubble_ctrl0", oc0, 0);
    chk("valid1", val1, q1.size() > 0);
    chk("ready1", rdy1, mr1());
    chk("stall1", sc1, s1);
    if (q1.size() > 0) begin
      chk("ctrl1", oc1, q1[0].c);
      chk("data1", od1, q1[0].d);
    end else chk("bubble_ctrl1", oc1, 0);
  end

  task automatic drv(input bit iv, input int unsigned dv, input bit ordy, input bit fl, input bit clr);
    in_valid = iv; in_data = DW'(dv); in_ctrl = CW'(dv * 7 + 1);
    out_ready = ordy; flush = fl; stall_clr = clr;
    @(posedge clk); #2;
  endtask

  initial begin
    #1 reset = 0;
    @(posedge clk); #2;
    reset = 1; en = 1;
    chk("rst_valid0", val0, 0);
    chk("rst_ready0", rdy0, 1);
    chk("rst_ctrl0", oc0, 0);
    chk("rst_data0", od0, 0);
    chk("rst_stall0", sc0, 0);
    chk("rst_ready1", rdy1, 1);
    for (int i = 0; i < 10; i++) begin
      drv(1, i, 1, 0, 0);
      chk("t1_data", od0, i);
      chk("t1_ready", rdy0, 1);
    end
    chk("t1_stall", sc0, 0);
    drv(0, 0, 1, 0, 1);
    drv(1, 'hA, 0, 0, 0);
    chk("t2_a", od0, 'hA);
    drv(1, 'hB, 0, 0, 0);
    chk("t2_skid_ready", rdy0, 0);
    drv(1, 'hC, 0, 0, 0);
    chk("t2_hold_a", od0, 'hA);
    drv(1, 'hC, 1, 0, 0);
    chk("t2_b", od0, 'hB);
    drv(1, 'hC, 1, 0, 0);
    chk("t2_c", od0, 'hC);
    chk("t2_stall", sc0, 2);
    drv(0, 0, 1, 0, 0);
    chk("t2_empty", val0, 0);
    drv(1, 'h11, 0, 0, 0);
    drv(1, 'h22, 0, 0, 0);
    chk("t3_full_ready", rdy0, 0);
    drv(1, 'h33, 0, 1, 0);
    chk("t3_valid", val0, 0);
    chk("t3_ctrl", oc0, 0);
    chk("t3_ready", rdy0, 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 0, 0);
      chk("t3_gone", val0, 0);
    end
    drv(1, 'h44, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("t4_pre", val0, 1);
    #1 reset = 0;
    #1;
    chk("t4_valid", val0, 0);
    chk("t4_ctrl", oc0, 0);
    chk("t4_data", od0, 0);
    chk("t4_stall", sc0, 0);
    chk("t4_ready", rdy0, 1);
    #2 reset = 1;
    @(posedge clk); #2;
    drv(1, 'h55, 1, 0, 0);
    chk("t4_first", od0, 'h55);
    drv(0, 0, 0, 0, 1);
    chk("t5_clr_pre", sc1, 0);
    drv(1, 'h66, 0, 0, 0);
    for (int i = 0; i < 20; i++) drv(0, 0, 0, 0, 0);
    chk("t5_sat", sc1, 15);
    drv(0, 0, 0, 0, 1);
    chk("t5_clr", sc1, 0);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 1, 0, 0);
    drv(1, 'h70, 1, 0, 0);
    chk("t6_a", od1, 'h70);
    drv(1, 'h71, 0, 0, 0);
    chk("t6_hold", od1, 'h70);
    chk("t6_ready_lo", rdy1, 0);
    drv(1, 'h72, 1, 0, 0);
    chk("t6_b", od1, 'h72);
    chk("t6_ready_hi", rdy1, 1);
    drv(1, 'h73, 0, 0, 0);
    chk("t6_hold_b", od1, 'h72);
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      in_data = DW'({$urandom, $urandom, $urandom, $urandom});
      in_ctrl = CW'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      stall_clr = $urandom_range(0, 39) == 0;
      @(posedge clk); #2;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
